wb_bus_arbiter2: RTL and testbench

- Shares one Wishbone slave port between two CPU-side masters: m0 is the data bus and m1 is the instruction bus.
- Sits between the core's ins/dat master buses and a single-ported memory or bridge, for builds without separate instruction and data fabrics.
- Grants are locked for a whole CYC. Arbitration is round-robin or fixed-priority. A slave-stall watchdog returns ERR to the stuck master.

---
 rtl/wb_bus_arbiter2.sv | 156 +++++++++++++++
 tb/tb_wb_bus_arbiter2.sv | 229 ++++++++++++++++++++++
 2 files changed

// File: rtl/wb_bus_arbiter2.sv
// Two-master Wishbone arbiter: m0 (data) and m1 (instruction) share one slave port.
// Grant is held for a whole CYC; a stalled slave is cut off by a watchdog that returns ERR.
module wb_bus_arbiter2 #(
   parameter int unsigned ROUND_ROBIN = 1,
   parameter int unsigned TIMEOUT     = 256
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        m0_cyc,
   input  logic        m0_stb,
   input  logic        m0_we,
   input  logic [3:0]  m0_sel,
   input  logic [31:0] m0_adr,
   input  logic [31:0] m0_dat_m,
   output logic [31:0] m0_dat_s,
   output logic        m0_ack,
   output logic        m0_err,
   input  logic        m1_cyc,
   input  logic        m1_stb,
   input  logic        m1_we,
   input  logic [3:0]  m1_sel,
   input  logic [31:0] m1_adr,
   input  logic [31:0] m1_dat_m,
   output logic [31:0] m1_dat_s,
   output logic        m1_ack,
   output logic        m1_err,
   output logic        s_cyc,
   output logic        s_stb,
   output logic        s_we,
   output logic [3:0]  s_sel,
   output logic [31:0] s_adr,
   output logic [31:0] s_dat_m,
   input  logic [31:0] s_dat_s,
   input  logic        s_ack,
   input  logic        s_err,
   output logic [1:0]  grant,
   output logic        timeout,
   input  logic        timeout_clr
);

   localparam int unsigned CW     = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
   localparam logic [CW-1:0] TO_VAL = CW'(TIMEOUT);
   localparam bit          WD_EN  = (TIMEOUT != 0);
   localparam bit          RR_EN  = (ROUND_ROBIN != 0);

   typedef struct packed {
      logic        cyc;
      logic        stb;
      logic        we;
      logic [3:0]  sel;
      logic [31:0] adr;
      logic [31:0] dat;
   } wb_req_t;

   // State encoding doubles as the one-hot grant vector.
   typedef enum logic [1:0] {
      IDLE = 2'b00,
      OWN0 = 2'b01,
      OWN1 = 2'b10
   } state_t;

   state_t          state, state_nxt;
   logic            last, last_nxt;       // 0 = m0 owned last, 1 = m1 owned last
   logic [CW-1:0]   wd_cnt, wd_cnt_nxt;
   logic            timeout_nxt;
   logic            wd_fire;
   wb_req_t         req0, req1, own_req;

   assign req0 = '{cyc: m0_cyc, stb: m0_stb, we: m0_we, sel: m0_sel, adr: m0_adr, dat: m0_dat_m};
   assign req1 = '{cyc: m1_cyc, stb: m1_stb, we: m1_we, sel: m1_sel, adr: m1_adr, dat: m1_dat_m};

   // Owner's request, zeroed when idle or when the owner has dropped cyc.
   always_comb begin
      own_req = '0;
      case (state)
         OWN0: if (m0_cyc) own_req = req0;
         OWN1: if (m1_cyc) own_req = req1;
         default: own_req = '0;
      endcase
   end

   // Slave ack in the same cycle takes precedence over the watchdog.
   assign wd_fire = WD_EN && (wd_cnt == TO_VAL) && own_req.stb && !s_ack;

   assign s_cyc   = own_req.cyc;
   assign s_stb   = own_req.stb & ~wd_fire;
   assign s_we    = own_req.we;
   assign s_sel   = own_req.sel;
   assign s_adr   = own_req.adr;
   assign s_dat_m = own_req.dat;

   assign grant    = 2'(state);
   assign m0_dat_s = s_dat_s;
   assign m1_dat_s = s_dat_s;
   assign m0_ack   = s_ack & (state == OWN0);
   assign m1_ack   = s_ack & (state == OWN1);
   assign m0_err   = (s_err | wd_fire) & (state == OWN0);
   assign m1_err   = (s_err | wd_fire) & (state == OWN1);

   // Arbitration, watchdog and sticky-flag next state.
   always_comb begin
      state_nxt   = state;
      last_nxt    = last;
      wd_cnt_nxt  = wd_cnt;
      timeout_nxt = timeout;

      case (state)
         IDLE: begin
            if (m0_cyc && m1_cyc)
               state_nxt = (RR_EN && !last) ? OWN1 : OWN0;
            else if (m0_cyc)
               state_nxt = OWN0;
            else if (m1_cyc)
               state_nxt = OWN1;
         end
         OWN0: begin
            if (!m0_cyc) begin
               last_nxt  = 1'b0;
               state_nxt = m1_cyc ? OWN1 : IDLE;
            end
         end
         OWN1: begin
            if (!m1_cyc) begin
               last_nxt  = 1'b1;
               state_nxt = m0_cyc ? OWN0 : IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase

      if (!WD_EN || wd_fire || s_ack || s_err || !own_req.cyc)
         wd_cnt_nxt = '0;
      else if (own_req.stb)
         wd_cnt_nxt = wd_cnt + CW'(1);

      if (wd_fire)
         timeout_nxt = 1'b1;
      else if (timeout_clr)
         timeout_nxt = 1'b0;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state   <= IDLE;
         last    <= 1'b1;
         wd_cnt  <= '0;
         timeout <= 1'b0;
      end else begin
         state   <= state_nxt;
         last    <= last_nxt;
         wd_cnt  <= wd_cnt_nxt;
         timeout <= timeout_nxt;
      end
   end

endmodule

// File: tb/tb_wb_bus_arbiter2.sv
// Bench for wb_bus_arbiter2: a round-robin/TIMEOUT=8 instance and a fixed-priority/TIMEOUT=0
// instance share stimulus; both are compared every cycle against an owner/last/count model.
module tb_wb_bus_arbiter2;

   logic        clk, rst;
   logic        c0, s0, w0, c1, s1, w1;
   logic [3:0]  sel0, sel1;
   logic [31:0] adr0, adr1, d0, d1, sdat;
   logic        sack, serr, tclr;

   logic [1:0][31:0] m0_dat_s_o, m1_dat_s_o, s_adr_o, s_dat_m_o;
   logic [1:0][3:0]  s_sel_o;
   logic [1:0][1:0]  grant_o;
   logic [1:0]       m0_ack_o, m0_err_o, m1_ack_o, m1_err_o;
   logic [1:0]       s_cyc_o, s_stb_o, s_we_o, timeout_o;

   int tests = 0;
   int fails = 0;
   int own[2];
   int last[2];
   int cnt[2];
   logic to[2];
   int fire_at;

   wb_bus_arbiter2 #(.ROUND_ROBIN(1), .TIMEOUT(8)) dut_rr (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc(c0), .m0_stb(s0), .m0_we(w0), .m0_sel(sel0), .m0_adr(adr0), .m0_dat_m(d0),
      .m0_dat_s(m0_dat_s_o[0]), .m0_ack(m0_ack_o[0]), .m0_err(m0_err_o[0]),
      .m1_cyc(c1), .m1_stb(s1), .m1_we(w1), .m1_sel(sel1), .m1_adr(adr1), .m1_dat_m(d1),
      .m1_dat_s(m1_dat_s_o[0]), .m1_ack(m1_ack_o[0]), .m1_err(m1_err_o[0]),
      .s_cyc(s_cyc_o[0]), .s_stb(s_stb_o[0]), .s_we(s_we_o[0]), .s_sel(s_sel_o[0]),
      .s_adr(s_adr_o[0]), .s_dat_m(s_dat_m_o[0]), .s_dat_s(sdat), .s_ack(sack), .s_err(serr),
      .grant(grant_o[0]), .timeout(timeout_o[0]), .timeout_clr(tclr)
   );

   wb_bus_arbiter2 #(.ROUND_ROBIN(0), .TIMEOUT(0)) dut_fp (
      .clk_i(clk), .rst_i(rst),
      .m0_cyc(c0), .m0_stb(s0), .m0_we(w0), .m0_sel(sel0), .m0_adr(adr0), .m0_dat_m(d0),
      .m0_dat_s(m0_dat_s_o[1]), .m0_ack(m0_ack_o[1]), .m0_err(m0_err_o[1]),
      .m1_cyc(c1), .m1_stb(s1), .m1_we(w1), .m1_sel(sel1), .m1_adr(adr1), .m1_dat_m(d1),
      .m1_dat_s(m1_dat_s_o[1]), .m1_ack(m1_ack_o[1]), .m1_err(m1_err_o[1]),
      .s_cyc(s_cyc_o[1]), .s_stb(s_stb_o[1]), .s_we(s_we_o[1]), .s_sel(s_sel_o[1]),
      .s_adr(s_adr_o[1]), .s_dat_m(s_dat_m_o[1]), .s_dat_s(sdat), .s_ack(sack), .s_err(serr),
      .grant(grant_o[1]), .timeout(timeout_o[1]), .timeout_clr(tclr)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s dut%0d observed=%0h expected=%0h", tag, k, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         own[k]  = -1;
         last[k] = 1;
         cnt[k]  = 0;
         to[k]   = 1'b0;
      end
   endtask

   // Expected outputs from owner/last/count, then advance the model one clock.
   task automatic check_dut(input int k);
      int o, other, tout;
      logic oc, os, ow, wd;
      logic [3:0] osel;
      logic [31:0] oadr, odat;
      o = own[k];
      tout = (k == 0) ? 8 : 0;
      oc = 1'b0; os = 1'b0; ow = 1'b0; osel = 4'h0; oadr = 32'h0; odat = 32'h0;
      if (o == 0 && c0) begin oc = 1'b1; os = s0; ow = w0; osel = sel0; oadr = adr0; odat = d0; end
      if (o == 1 && c1) begin oc = 1'b1; os = s1; ow = w1; osel = sel1; oadr = adr1; odat = d1; end
      wd = (tout > 0) && (cnt[k] == tout) && os && !sack;

      chk("grant", k, 64'(grant_o[k]), 64'((o == 0) ? 2'b01 : (o == 1) ? 2'b10 : 2'b00));
      chk("s_ctl", k, 64'({s_cyc_o[k], s_stb_o[k], s_we_o[k], s_sel_o[k]}),
          64'({oc, os & !wd, ow, osel}));
      chk("s_adr", k, 64'(s_adr_o[k]), 64'(oadr));
      chk("s_dat_m", k, 64'(s_dat_m_o[k]), 64'(odat));
      chk("m_resp", k, 64'({m0_ack_o[k], m0_err_o[k], m1_ack_o[k], m1_err_o[k]}),
          64'({sack & (o == 0), (serr | wd) & (o == 0), sack & (o == 1), (serr | wd) & (o == 1)}));
      chk("m_dat_s", k, {m0_dat_s_o[k], m1_dat_s_o[k]}, {sdat, sdat});
      chk("timeout", k, 64'(timeout_o[k]), 64'(to[k]));

      if (!rst) begin
         if (tout == 0 || wd || sack || serr || !oc) cnt[k] = 0;
         else if (os) cnt[k] = cnt[k] + 1;
         if (wd) to[k] = 1'b1;
         else if (tclr) to[k] = 1'b0;
         if (o < 0) begin
            if (c0 && c1) own[k] = (k == 0 && last[k] == 0) ? 1 : 0;
            else if (c0) own[k] = 0;
            else if (c1) own[k] = 1;
         end else if (!oc) begin
            last[k] = o;
            other = 1 - o;
            own[k] = ((other == 0) ? c0 : c1) ? other : -1;
         end
      end
   endtask

   // Inputs are set just after a rising edge; checks happen on the falling edge.
   task automatic step();
      @(negedge clk);
      if (rst) model_reset();
      check_dut(0);
      check_dut(1);
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; tclr = 1'b0; sack = 1'b0; serr = 1'b0; sdat = 32'h0;
      c0 = 1'b0; s0 = 1'b0; w0 = 1'b0; sel0 = 4'h0; adr0 = 32'h0; d0 = 32'h0;
      c1 = 1'b0; s1 = 1'b0; w1 = 1'b0; sel1 = 4'h0; adr1 = 32'h0; d1 = 32'h0;
      model_reset();
      step();
      rst = 1'b0;
      step();

      // Simultaneous requests: m0 first, hand-off to m1 without an idle cycle, then m0 again.
      c0 = 1; s0 = 1; sel0 = 4'hF; adr0 = 32'h0000_2000; d0 = 32'h1111_1111;
      c1 = 1; s1 = 1; sel1 = 4'hF; adr1 = 32'h0000_8000; d1 = 32'h2222_2222;
      step();
      chk("t2_tie_first", 0, 64'(grant_o[0]), 64'(2'b01));
      chk("t2_tie_first", 1, 64'(grant_o[1]), 64'(2'b01));
      sack = 1; sdat = 32'h0BAD_F00D; step(); sack = 0;
      c0 = 0; step();
      chk("t2_handoff", 0, 64'(grant_o[0]), 64'(2'b10));
      sack = 1; step(); sack = 0;
      c1 = 0; step();
      chk("t2_release", 0, 64'(grant_o[0]), 64'(2'b00));
      step();
      c0 = 1; c1 = 1; step();
      chk("t2_tie_second", 0, 64'(grant_o[0]), 64'(2'b01));

      // m0 was last owner: round-robin favours m1, fixed priority still m0.
      c0 = 0; c1 = 0; step(); step();
      c0 = 1; c1 = 1; step();
      chk("t3_tie_rr", 0, 64'(grant_o[0]), 64'(2'b10));
      chk("t3_tie_fp", 1, 64'(grant_o[1]), 64'(2'b01));
      for (int j = 0; j < 8; j++) begin
         c0 = (j % 3) != 2;
         c1 = (j % 4) != 3;
         sack = j[0];
         step();
      end
      c0 = 0; c1 = 0; sack = 0; step(); step();

      // Single read from m0 acked two cycles later.
      c0 = 1; s0 = 1; w0 = 0; adr0 = 32'h0000_1000;
      step();
      chk("t1_grant", 0, 64'(grant_o[0]), 64'(2'b01));
      chk("t1_adr", 0, 64'(s_adr_o[0]), 64'(32'h0000_1000));
      step();
      sack = 1; sdat = 32'hCAFE_F00D; #1;
      chk("t1_ack", 0, 64'({m0_ack_o[0], m1_ack_o[0]}), 64'(2'b10));
      chk("t1_rdata", 0, 64'(m0_dat_s_o[0]), 64'(32'hCAFE_F00D));
      step();
      sack = 0; c0 = 0; step(); step();

      // Four-beat burst from m0 with m1 waiting from beat 1.
      c0 = 1; s0 = 1; adr0 = 32'h0000_3000; step();
      c1 = 1; s1 = 1;
      for (int b = 0; b < 4; b++) begin
         sack = 1; adr0 = adr0 + 32'd4;
         step();
         chk("t4_locked", 0, 64'(grant_o[0]), 64'(2'b01));
      end
      sack = 0; c0 = 0; step();
      chk("t4_handoff", 0, 64'(grant_o[0]), 64'(2'b10));
      c1 = 0; step(); step();

      // m1 strobes into a dead slave until the watchdog fires.
      c1 = 1; s1 = 1; w1 = 0; adr1 = 32'h0000_4000; step();
      fire_at = 0;
      for (int i = 1; i <= 20; i++) begin
         if (fire_at == 0 && m1_err_o[0]) begin
            fire_at = i;
            chk("t5_stb_low", 0, 64'(s_stb_o[0]), 64'(0));
         end
         step();
         if (fire_at != 0) c1 = 0;
      end
      chk("t5_fire_cycle", 0, 64'(fire_at), 64'(9));
      chk("t5_sticky", 0, 64'(timeout_o[0]), 64'(1));
      tclr = 1; step(); tclr = 0;
      chk("t5_cleared", 0, 64'(timeout_o[0]), 64'(0));

      // Asynchronous reset in the middle of an m1 write.
      c1 = 1; s1 = 1; w1 = 1; d1 = 32'h5A5A_5A5A; step(); step();
      sack = 1; rst = 1; #1;
      chk("t6_scyc", 0, 64'(s_cyc_o[0]), 64'(0));
      chk("t6_grant", 0, 64'(grant_o[0]), 64'(2'b00));
      chk("t6_noack", 0, 64'(m1_ack_o[0]), 64'(0));
      model_reset();
      step();
      rst = 0; sack = 0; c1 = 0; step();
      c0 = 1; c1 = 1; step();
      chk("t6_tie_after_reset", 0, 64'(grant_o[0]), 64'(2'b01));
      c0 = 0; c1 = 0; step(); step();

      // Random traffic against the model.
      for (int n = 0; n < 1500; n++) begin
         if ($urandom_range(0, 5) == 0) c0 = ~c0;
         if ($urandom_range(0, 5) == 0) c1 = ~c1;
         s0 = ($urandom_range(0, 7) != 0); s1 = ($urandom_range(0, 7) != 0);
         w0 = 1'($urandom); w1 = 1'($urandom);
         sel0 = 4'($urandom); sel1 = 4'($urandom);
         adr0 = $urandom; adr1 = $urandom; d0 = $urandom; d1 = $urandom; sdat = $urandom;
         sack = ($urandom_range(0, 3) == 0);
         serr = ($urandom_range(0, 15) == 0);
         tclr = ($urandom_range(0, 31) == 0);
         rst  = ($urandom_range(0, 299) == 0);
         step();
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
